pu_mult_arbiter: RTL
====================

PU_MULT_ARBITER -- requirements
Module: pu_mult_arbiter

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 8, operand/result width.
- ATTR_WIDTH, default 4, attribute bus is ATTR_WIDTH+1 bits.
- INVALID, default 0, index of the invalid bit in attribute buses.
- WAIT_CYCLES, default 3, idle cycles between second operand write and result read.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester operation request.
- req_ready  out  2  one-cycle accept pulse to the granted requester.
- req_a  in  2*DATA_WIDTH  operand A; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_b  in  2*DATA_WIDTH  operand B; same slicing as req_a.
- req_inv_a  in  2  invalid flag for operand A, per requester.
- req_inv_b  in  2  invalid flag for operand B, per requester.
- rsp_valid  out  2  result available for requester i.
- rsp_ready  in  2  requester i consumes the result.
- rsp_data  out  DATA_WIDTH  result data, shared by both requesters.
- rsp_invalid  out  1  result invalid flag.
- pu_signal_wr  out  1  multiplier PU write strobe.
- pu_signal_sel  out  1  multiplier PU operand select.
- pu_data_in  out  DATA_WIDTH  multiplier PU operand data.
- pu_attr_in  out  ATTR_WIDTH+1  multiplier PU attributes.
- pu_signal_oe  out  1  multiplier PU output enable.
- pu_data_out  in  DATA_WIDTH  multiplier PU result.
- pu_attr_out  in  ATTR_WIDTH+1  multiplier PU result attributes.

Function
REQ-003 FSM states SHALL be IDLE, WR_A, WR_B, WAIT, READ, RESP; exactly one transaction SHALL be in flight.
REQ-004 In IDLE with any req_valid high:
- grant one requester.
- pulse its req_ready for that cycle.
- latch its operands and inv flags.
- go to WR_A.
REQ-005 Arbitration SHALL be round-robin; the requester other than the last granted has priority; after reset requester 0 has priority.
REQ-006 WR_A (1 cycle) SHALL drive wr=1, sel=0, data=latched A, attr bit INVALID=inv_a with all other attr bits 0.
REQ-007 WR_B (1 cycle) SHALL drive wr=1, sel=1, data=latched B, attr bit INVALID=inv_b.
REQ-008 WAIT SHALL last exactly WAIT_CYCLES cycles; the down-counter SHALL reload on WR_B entry.
REQ-009 READ (1 cycle) SHALL assert pu_signal_oe and register pu_data_out into rsp_data and pu_attr_out[INVALID] into rsp_invalid.
REQ-010 RESP SHALL hold rsp_valid[grant] high and keep rsp_data and rsp_invalid stable until rsp_ready[grant] is high.
REQ-011 On the RESP handshake cycle the FSM SHALL return to IDLE; a new grant earliest one cycle later.
REQ-012 rsp_ready on the non-granted index SHALL be ignored.
REQ-013 Outside WR_A/WR_B, pu_signal_wr, pu_signal_sel, pu_data_in and pu_attr_in SHALL be 0.
REQ-014 Outside READ, pu_signal_oe SHALL be 0.
REQ-015 req_valid deassertion after grant SHALL NOT abort the transaction.
REQ-016 Request-to-rsp_valid latency SHALL be WAIT_CYCLES+4 cycles from the accept cycle.
REQ-017 The result is the DATA_WIDTH-bit product as returned by the PU; no widening or saturation.

Reset
REQ-018 While rst is high:
- state=IDLE, priority=requester 0.
- req_ready=0, rsp_valid=0, rsp_data=0, rsp_invalid=0.
- all pu_* outputs=0.
REQ-019 Reset asserted mid-transaction SHALL discard it with no response; the next transaction SHALL start from IDLE.

Verification
REQ-020 Req0 A=3, B=5, no inv -> req_ready[0] pulse; WR_A/WR_B strobes; oe one cycle; rsp_valid[0] with rsp_data=15, rsp_invalid=0 after WAIT_CYCLES+4 cycles.
REQ-021 Req1 A=2, B=4, inv_a=1 -> pu_attr_in[INVALID]=1 during WR_A; rsp_invalid follows the PU attr bit (1).
REQ-022 Both valid after reset (req0 2*3, req1 4*4) -> req0 served first (6), then req1 (16); simultaneous repeat alternates.
REQ-023 rsp_ready held low 10 cycles -> rsp_valid and rsp_data stable throughout; no new req_ready pulse.
REQ-024 rst pulsed during WAIT -> all outputs 0 next cycle, no rsp_valid; a following request completes correctly.

Source files
------------

// File: rtl/pu_mult_arbiter_if.sv
// pu_mult_arbiter_if: requester request/response and multiplier PU signal bundle
interface pu_mult_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ATTR_WIDTH = 4
);
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [2*DATA_WIDTH-1:0] req_a;
    logic [2*DATA_WIDTH-1:0] req_b;
    logic [1:0] req_inv_a;
    logic [1:0] req_inv_b;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic rsp_invalid;
    logic pu_signal_wr;
    logic pu_signal_sel;
    logic [DATA_WIDTH-1:0] pu_data_in;
    logic [ATTR_WIDTH:0] pu_attr_in;
    logic pu_signal_oe;
    logic [DATA_WIDTH-1:0] pu_data_out;
    logic [ATTR_WIDTH:0] pu_attr_out;
    modport master (
        output req_valid, req_a, req_b, req_inv_a, req_inv_b, rsp_ready, pu_data_out, pu_attr_out,
        input req_ready, rsp_valid, rsp_data, rsp_invalid,
        input pu_signal_wr, pu_signal_sel, pu_data_in, pu_attr_in, pu_signal_oe
    );
    modport slave (
        input req_valid, req_a, req_b, req_inv_a, req_inv_b, rsp_ready, pu_data_out, pu_attr_out,
        output req_ready, rsp_valid, rsp_data, rsp_invalid,
        output pu_signal_wr, pu_signal_sel, pu_data_in, pu_attr_in, pu_signal_oe
    );
endinterface

// File: rtl/pu_mult_arbiter.sv
// pu_mult_arbiter: round-robin arbiter sharing one multiplier PU between two requesters
module pu_mult_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ATTR_WIDTH = 4,
    parameter int INVALID = 0,
    parameter int WAIT_CYCLES = 3
) (
    input logic clk,
    input logic rst,
    pu_mult_arbiter_if.slave bus
);
    localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
    typedef enum logic [2:0] {IDLE, WR_A, WR_B, WAIT, READ, RESP} state_t;
    state_t state, state_nxt;
    logic prio, grant, pick, on, wr_a, wr_b, inv_a, inv_b, inv, unused_attr;
    logic [DATA_WIDTH-1:0] op_a, op_b, data;
    logic [CW-1:0] cnt;
    logic [ATTR_WIDTH:0] inv_mask;
    assign on = !rst;
    assign inv_mask = (ATTR_WIDTH+1)'(1) << INVALID;
    assign pick = bus.req_valid[prio] ? prio : !prio;
    assign unused_attr = ^bus.pu_attr_out;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prio <= 1'b0;
            grant <= 1'b0;
            cnt <= '0;
            op_a <= '0;
            op_b <= '0;
            inv_a <= 1'b0;
            inv_b <= 1'b0;
            data <= '0;
            inv <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && |bus.req_valid) begin
                grant <= pick;
                prio <= !pick;
                op_a <= pick ? bus.req_a[2*DATA_WIDTH-1 -: DATA_WIDTH] : bus.req_a[DATA_WIDTH-1:0];
                op_b <= pick ? bus.req_b[2*DATA_WIDTH-1 -: DATA_WIDTH] : bus.req_b[DATA_WIDTH-1:0];
                inv_a <= bus.req_inv_a[pick];
                inv_b <= bus.req_inv_b[pick];
            end
            // reload as WR_B is entered so WAIT sees the full count on its first cycle
            if (state == WR_A) cnt <= CW'(WAIT_CYCLES - 1);
            else if (state == WAIT) cnt <= cnt - CW'(1);
            if (state == READ) begin
                data <= bus.pu_data_out;
                inv <= bus.pu_attr_out[INVALID];
            end
        end
    end
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: state_nxt = |bus.req_valid ? WR_A : IDLE;
            WR_A: state_nxt = WR_B;
            WR_B: state_nxt = WAIT;
            WAIT: state_nxt = cnt == '0 ? READ : WAIT;
            READ: state_nxt = RESP;
            RESP: state_nxt = bus.rsp_ready[grant] ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end
    assign wr_a = on && state == WR_A;
    assign wr_b = on && state == WR_B;
    assign bus.req_ready = {2{on && state == IDLE && |bus.req_valid}} & (pick ? 2'b10 : 2'b01);
    assign bus.rsp_valid = {2{on && state == RESP}} & (grant ? 2'b10 : 2'b01);
    assign bus.rsp_data = on ? data : '0;
    assign bus.rsp_invalid = on && inv;
    assign bus.pu_signal_wr = wr_a || wr_b;
    assign bus.pu_signal_sel = wr_b;
    assign bus.pu_data_in = wr_a ? op_a : wr_b ? op_b : '0;
    assign bus.pu_attr_in = ((wr_a && inv_a) || (wr_b && inv_b)) ? inv_mask : '0;
    assign bus.pu_signal_oe = on && state == READ;
endmodule
